// File: rtl/usb_word_framer_pkg.sv
// Shared constants for usb_word_framer: state encoding, trailer layout, default length.
// The trailer marker switches to MARK_TS when FRAMER_TS_EN is defined.
package usb_framer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_LO  = 2'd0;
  localparam state_t S_HI  = 2'd1;
  localparam state_t S_TRL = 2'd2;
  localparam state_t S_TS  = 2'd3;

  localparam logic [2:0] MARK_PLAIN = 3'b101;
  localparam logic [2:0] MARK_TS    = 3'b111;

  localparam int TRL_MARK_LSB  = 13;
  localparam int TRL_TRUNC_BIT = 12;
  localparam int TRL_ODD_BIT   = 11;
  localparam int TRL_CNT_W     = 11;

  localparam int DEF_MAX_LEN = 1028;

  function automatic logic [15:0] make_trailer(input logic [2:0] mark, input logic trunc,
                                               input logic odd, input logic [TRL_CNT_W-1:0] cnt);
    logic [15:0] t;
    t = '0;
    t[TRL_MARK_LSB +: 3]      = mark;
    t[TRL_TRUNC_BIT]          = trunc;
    t[TRL_ODD_BIT]            = odd;
    t[0 +: TRL_CNT_W]         = cnt;
    return t;
  endfunction

endpackage

// File: rtl/usb_word_framer_if.sv
// Byte-in / word-out handshake bundle for usb_word_framer.
// slave is the framer's view; master is the surrounding FIFO / sink side.
interface usb_word_framer_if;
  logic [7:0]  in_data_i;
  logic        in_last_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] ts_i;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] trunc_cnt_o;

  modport slave (
    input  in_data_i, in_last_i, in_valid_i, ts_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o, trunc_cnt_o
  );

  modport master (
    output in_data_i, in_last_i, in_valid_i, ts_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o, trunc_cnt_o
  );
endinterface

// File: rtl/usb_word_framer_word_reg.sv
// usb_word_reg: single-entry valid/ready output slot; a loaded word holds until accepted.
module usb_word_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        ready,
  output logic        valid,
  output logic [15:0] dout,
  output logic        free
);
  assign free = !valid | ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/usb_word_framer.sv
// Packs a byte stream into 16-bit little-endian words and closes each packet with a
// length/status trailer. FRAMER_TS_EN adds a timestamp word after each trailer.
module usb_word_framer
  import usb_framer_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input logic              clk_i,
  input logic              reset_n_i,
  usb_word_framer_if.slave bus
);
  localparam logic [TRL_CNT_W-1:0] MAX_CNT = TRL_CNT_W'(MAX_LEN);

`ifdef FRAMER_TS_EN
  localparam logic [2:0] MARK     = MARK_TS;
  localparam state_t     TRL_NEXT = S_TS;
  logic [15:0] ts_q;
`else
  localparam logic [2:0] MARK     = MARK_PLAIN;
  localparam state_t     TRL_NEXT = S_LO;
  logic unused_ts;
  assign unused_ts = ^bus.ts_i;
`endif

  state_t               state;
  logic [TRL_CNT_W-1:0] cnt;
  logic [7:0]           lo;
  logic                 trunc, odd, run;
  logic [15:0]          trunc_cnt;
  logic                 free, load, accept, full;
  logic [15:0]          word;

  assign full           = cnt == MAX_CNT;
  // run holds in_ready low until the first edge after reset release
  assign bus.in_ready_o = run & free & (state == S_LO || state == S_HI);
  assign accept         = bus.in_valid_i & bus.in_ready_o;
  assign bus.trunc_cnt_o = trunc_cnt;

  always_comb begin
    load = 1'b0;
    word = '0;
    case (state)
      S_LO:  if (accept && !full && bus.in_last_i) begin
               load = 1'b1;
               word = {8'h00, bus.in_data_i};
             end
      S_HI:  if (accept) begin
               load = 1'b1;
               word = {bus.in_data_i, lo};
             end
      S_TRL: if (free) begin
               load = 1'b1;
               word = make_trailer(MARK, trunc, odd, cnt);
             end
      default: if (free) begin
               load = 1'b1;
`ifdef FRAMER_TS_EN
               word = ts_q;
`endif
             end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= S_LO;
      cnt       <= '0;
      lo        <= '0;
      trunc     <= 1'b0;
      odd       <= 1'b0;
      run       <= 1'b0;
      trunc_cnt <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        S_LO: if (accept) begin
          if (full) begin
            // over-length bytes are consumed and dropped; count holds
            trunc <= 1'b1;
            if (bus.in_last_i) begin
              odd   <= 1'b0;
              state <= S_TRL;
            end
          end else if (bus.in_last_i) begin
            cnt   <= cnt + 1'b1;
            odd   <= 1'b1;
            state <= S_TRL;
          end else begin
            lo    <= bus.in_data_i;
            cnt   <= cnt + 1'b1;
            state <= S_HI;
          end
        end
        S_HI: if (accept) begin
          cnt <= cnt + 1'b1;
          if (bus.in_last_i) begin
            odd   <= 1'b0;
            state <= S_TRL;
          end else begin
            state <= S_LO;
          end
        end
        S_TRL: if (free) begin
          if (trunc && trunc_cnt != 16'hFFFF) trunc_cnt <= trunc_cnt + 16'd1;
          cnt   <= '0;
          trunc <= 1'b0;
          odd   <= 1'b0;
          state <= TRL_NEXT;
        end
        default: if (free) state <= S_LO;
      endcase
    end
  end

`ifdef FRAMER_TS_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                               ts_q <= '0;
    else if (accept && state == S_LO && cnt == '0) ts_q <= bus.ts_i;
  end
`endif

  usb_word_reg u_word_reg (
    .clk   (clk_i),
    .rst_n (reset_n_i),
    .load  (load),
    .din   (word),
    .ready (bus.out_ready_i),
    .valid (bus.out_valid_o),
    .dout  (bus.out_data_o),
    .free  (free)
  );
endmodule

// File: tb/tb_usb_word_framer.sv
// Self-checking bench for usb_word_framer; expected words come from a frame-level model.
module tb_usb_word_framer;
  localparam int MAX_LEN = 1028;
`ifdef FRAMER_TS_EN
  localparam int MARK = 7;
`else
  localparam int MARK = 5;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  usb_word_framer_if bus();

  usb_word_framer #(.MAX_LEN(MAX_LEN)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  int          checks = 0;
  int          failures = 0;
  int          exp_trunc = 0;
  logic [8:0]  src_q[$];
  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  bit          gap_en = 1'b0;
  bit          rand_sink = 1'b0;

  // byte source: drives head of src_q, pops once a handshake was seen
  initial begin
    bit take;
    take = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (take && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0 && !(gap_en && $urandom_range(0, 2) == 0)) begin
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = src_q[0][7:0];
        bus.in_last_i  = src_q[0][8];
      end else begin
        bus.in_valid_i = 1'b0;
      end
      @(negedge clk);
      take = bus.in_valid_i && bus.in_ready_o && rst_n;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_sink) bus.out_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk)
    if (rst_n && bus.out_valid_o && bus.out_ready_i) got.push_back(bus.out_data_o);

  // Frame-level model: keep the first MAX_LEN bytes, pair them little-endian, then trailer.
  function automatic void add_frame(input logic [7:0] fr[$]);
    int n, e, trl;
    bit tr;
    n  = fr.size();
    e  = (n > MAX_LEN) ? MAX_LEN : n;
    tr = n > MAX_LEN;
    for (int i = 0; i < n; i++) src_q.push_back({i == n - 1, fr[i]});
    for (int i = 0; i < e; i += 2)
      exp_q.push_back((i + 1 < e) ? {fr[i+1], fr[i]} : {8'h00, fr[i]});
    trl = MARK * 8192 + int'(tr) * 4096 + (e % 2) * 2048 + e;
    exp_q.push_back(16'(trl));
`ifdef FRAMER_TS_EN
    exp_q.push_back(16'h1234);
`endif
    if (tr && exp_trunc < 65535) exp_trunc++;
  endfunction

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (src_q.size() == 0 && got.size() >= exp_q.size()) ok = 1'b1;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b required=0", bus.out_valid_o); end
    checks++; if (bus.out_data_o !== 16'h0) begin failures++; $display("FAIL rst_data got=%h required=0000", bus.out_data_o); end
    checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b required=0", bus.in_ready_o); end
    checks++; if (bus.trunc_cnt_o !== 16'h0) begin failures++; $display("FAIL rst_trunc got=%h required=0000", bus.trunc_cnt_o); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL rdy_pre_edge got=%b required=0", bus.in_ready_o); end
    @(negedge clk);
    checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL rdy_after_edge got=%b required=1", bus.in_ready_o); end
  endtask

  task automatic test_basic();
    logic [7:0] fr[$];
    bit ok;
    got.delete(); exp_q.delete();
    rand_sink = 1'b0; bus.out_ready_i = 1'b1; gap_en = 1'b0;
    fr = '{8'h11, 8'h22, 8'h33};
    add_frame(fr);
    wait_done(200, ok);
    checks++; if (!ok || got.size() != exp_q.size()) begin failures++; $display("FAIL basic_len got=%0d required=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL basic_word[%0d] got=%h required=%h", i, got[i], exp_q[i]); end
    end
    checks++; if (bus.trunc_cnt_o !== 16'h0) begin failures++; $display("FAIL basic_trunc got=%h required=0000", bus.trunc_cnt_o); end
  endtask

  task automatic test_stall();
    logic [7:0] fr[$];
    bit ok, seen;
    got.delete(); exp_q.delete();
    @(posedge clk); #2 bus.out_ready_i = 1'b0;
    fr = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    add_frame(fr);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = bus.out_valid_o;
    end
    checks++; if (!seen) begin failures++; $display("FAIL stall_first_word got=none required=valid"); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (bus.out_data_o !== 16'hA2A1 || bus.out_valid_o !== 1'b1) begin
        failures++; $display("FAIL stall_hold[%0d] got=%h/%b required=a2a1/1", k, bus.out_data_o, bus.out_valid_o); end
      checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b required=0", k, bus.in_ready_o); end
    end
    @(posedge clk); #2 bus.out_ready_i = 1'b1;
    wait_done(200, ok);
    checks++; if (!ok || got.size() != exp_q.size()) begin failures++; $display("FAIL stall_len got=%0d required=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL stall_word[%0d] got=%h required=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] fr[$];
    bit rq[$];
    bit ok, done;
    got.delete(); exp_q.delete();
    fr = '{8'($urandom)}; add_frame(fr);
    fr = '{8'($urandom)}; add_frame(fr);
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.in_valid_i) rq.push_back(bus.in_ready_o);
      else if (src_q.size() == 0) done = 1'b1;
    end
    checks++; if (rq.size() != 3 || rq[0] !== 1'b1 || rq[1] !== 1'b0 || rq[2] !== 1'b1) begin
      failures++; $display("FAIL b2b_ready_pattern got=%p required=1,0,1", rq); end
    wait_done(200, ok);
    checks++; if (!ok || got.size() != exp_q.size()) begin failures++; $display("FAIL b2b_len got=%0d required=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_word[%0d] got=%h required=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_trunc();
    logic [7:0] fr[$];
    bit ok;
    got.delete(); exp_q.delete();
    rand_sink = 1'b1; gap_en = 1'b1;
    for (int i = 0; i < 1030; i++) fr.push_back(8'($urandom));
    add_frame(fr);
    fr = '{8'($urandom), 8'($urandom)};
    add_frame(fr);
    wait_done(20000, ok);
    checks++; if (!ok || got.size() != exp_q.size()) begin failures++; $display("FAIL trunc_len got=%0d required=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL trunc_word[%0d] got=%h required=%h", i, got[i], exp_q[i]); end
    end
    checks++; if (bus.trunc_cnt_o !== 16'(exp_trunc)) begin failures++; $display("FAIL trunc_cnt got=%0d required=%0d", bus.trunc_cnt_o, exp_trunc); end
    rand_sink = 1'b0; gap_en = 1'b0;
    @(posedge clk); #2 bus.out_ready_i = 1'b1;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] fr[$];
    bit ok;
    src_q.push_back({1'b0, 8'h5A});
    src_q.push_back({1'b0, 8'hC3});
    for (int c = 0; c < 50 && src_q.size() != 0; c++) @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== 16'h0) begin
      failures++; $display("FAIL midrst_out got=%h/%b required=0000/0", bus.out_data_o, bus.out_valid_o); end
    checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b required=0", bus.in_ready_o); end
    checks++; if (bus.trunc_cnt_o !== 16'h0) begin failures++; $display("FAIL midrst_trunc got=%h required=0000", bus.trunc_cnt_o); end
    exp_trunc = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    got.delete(); exp_q.delete();
    fr = '{8'($urandom), 8'($urandom)};
    add_frame(fr);
    wait_done(200, ok);
    checks++; if (!ok || got.size() != exp_q.size()) begin failures++; $display("FAIL midrst_len got=%0d required=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL midrst_word[%0d] got=%h required=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] fr[$];
    bit ok;
    got.delete(); exp_q.delete();
    rand_sink = 1'b1; gap_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      fr.delete();
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) fr.push_back(8'($urandom));
      add_frame(fr);
    end
    wait_done(5000, ok);
    checks++; if (!ok || got.size() != exp_q.size()) begin failures++; $display("FAIL rand_len got=%0d required=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rand_word[%0d] got=%h required=%h", i, got[i], exp_q[i]); end
    end
    checks++; if (bus.trunc_cnt_o !== 16'(exp_trunc)) begin failures++; $display("FAIL rand_trunc got=%0d required=%0d", bus.trunc_cnt_o, exp_trunc); end
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = 8'h00;
    bus.in_last_i   = 1'b0;
    bus.ts_i        = 16'h1234;
    bus.out_ready_i = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_trunc();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usb_word_framer.md
Name: usb_word_framer

Overview:
- Consumes the byte stream from the read side of the capture CDC FIFO in the host-interface clock domain.
- Packs bytes into 16-bit little-endian words for the host slave-FIFO writer.
- Terminates each USB packet with a trailer word carrying length and status.
- Enforces a maximum packet length: over-length packets are truncated and flagged, never stalled.

Parameters:
- MAX_LEN, 1028: maximum bytes emitted per frame. Must be even and ≤ 2047; bytes beyond it are dropped.

Ports:
- clk_i  in  1  host-interface clock
- reset_n_i  in  1  asynchronous active-low reset
- in_data_i  in  8  captured byte (FIFO rd_data bits [7:0])
- in_last_i  in  1  last byte of USB packet (FIFO rd_data bit [8])
- in_valid_i  in  1  byte available (FIFO rd_valid)
- in_ready_o  out  1  byte consumed this cycle when in_valid_i & in_ready_o (drives FIFO rd_en)
- ts_i  in  16  free-running timestamp; used only with FRAMER_TS_EN
- out_data_o  out  16  output word
- out_valid_o  out  1  out_data_o valid
- out_ready_i  in  1  sink accepts word when out_valid_o & out_ready_i
- trunc_cnt_o  out  16  saturating count of truncated frames

Behaviour:
- Reset is asynchronous, active-low. All state is cleared while reset_n_i = 0:
  - out_valid_o = 0, out_data_o = 0, in_ready_o = 0, trunc_cnt_o = 0
  - state = S_LO, byte count = 0
- in_ready_o rises the first cycle after reset_n_i deasserts.
- Reset asserted mid-frame discards the partial frame; no trailer is emitted.
- Output is a single registered slot. A slot is free when !out_valid_o | out_ready_i. A loaded word holds stable until accepted.
- in_ready_o = slot free & state in {S_LO, S_HI}.
- State S_LO (no byte held):
  - Accept, not last: store lo = byte, cnt += 1, go to S_HI; no output.
  - Accept, last: emit {8'h00, byte}, cnt += 1, odd = 1, go to S_TRL.
- State S_HI (low byte held):
  - Accept, not last: emit {byte, lo}, cnt += 1, go to S_LO.
  - Accept, last: emit {byte, lo}, cnt += 1, odd = 0, go to S_TRL.
- State S_TRL:
  - in_ready_o = 0.
  - When the slot is free, load trailer {3'b101, trunc, odd, cnt[10:0]}.
  - Then clear cnt, trunc and odd, and go to S_LO (S_TS with FRAMER_TS_EN).
- Latency: a word is visible on out_data_o the cycle after the completing byte is accepted. The trailer follows in the first free-slot cycle after the last data word is loaded.
- Truncation: when cnt == MAX_LEN (state is always S_LO, since MAX_LEN is even):
  - Further bytes are still accepted (in_ready_o as normal) but not emitted; trunc = 1, cnt holds.
  - A dropped byte with last goes directly to S_TRL with odd = 0.
  - trunc_cnt_o increments once per truncated frame, at trailer load; saturates at 16'hFFFF.
- Back-to-back frames: the first byte of the next frame is accepted no earlier than the cycle after the trailer loads.
- Every frame carries ≥ 1 byte; zero-length frames are impossible.

Optional Feature:
- FRAMER_TS_EN defined:
  - ts_i is sampled when the first byte of a frame is accepted.
  - After the trailer, state S_TS emits the sampled value as one extra word (in_ready_o = 0 during S_TS), then goes to S_LO.
  - Trailer bits [15:13] = 3'b111 to mark that a timestamp word follows.
- FRAMER_TS_EN undefined: ts_i is ignored, S_TS does not exist, trailer marker is 3'b101.

Decomposition:
- Package usb_framer_pkg:
  - state encoding (S_LO, S_HI, S_TRL, S_TS)
  - trailer marker constants 3'b101 / 3'b111
  - trailer field bit positions
  - default MAX_LEN
- Sub-module usb_word_reg: single-entry valid/ready holding register. Provides a load strobe and slot-free flag, and is instantiated once.
- Framing state machine and counters stay in the top module.

Test Plan:
- 3-byte frame 0x11, 0x22, 0x33 (last), sink always ready -> words 0x2211, 0x0033, trailer 0xA803; trunc_cnt_o = 0.
- 4-byte frame 0xA1..0xA4 with out_ready_i low for 5 cycles after first word -> out_data_o held at 0xA2A1, in_ready_o = 0 while stalled; then 0xA4A3, trailer 0xA004; no byte lost.
- 1030-byte frame with MAX_LEN = 1028 -> 514 data words, trailer 0xB404, trunc_cnt_o = 1; the following 2-byte frame has trailer 0xA002.
- Two 1-byte frames back-to-back with in_valid_i held high -> 0x00xx, 0xA801, 0x00yy, 0xA801; in_ready_o low exactly during each S_TRL cycle.
- reset_n_i pulsed low after 2 bytes of a frame -> outputs cleared immediately; the next 2-byte frame yields one data word and trailer 0xA002 only.
- FRAMER_TS_EN, ts_i = 0x1234 at first byte of a 2-byte frame -> data word, trailer 0xE002, then 0x1234.
